// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: widths, opcodes, NOP encoding and fetch FSM states.
package rv32i_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ILEN   = 32;
  localparam int unsigned OP_W   = 7;
  localparam int unsigned F3_W   = 3;

  localparam logic [OP_W-1:0] OPC_OP_IMM = 7'h13;
  localparam logic [OP_W-1:0] OPC_BRANCH = 7'h63;
  localparam logic [OP_W-1:0] OPC_JAL    = 7'h6F;
  localparam logic [OP_W-1:0] OPC_JALR   = 7'h67;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP = {25'h0, OPC_OP_IMM};

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_HOLD = 2'd2
  } if_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: imem handshake, UC/datapath redirect and decode handshake.
interface instr_fetch_if;
  import rv32i_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            pc_src;
  logic [XLEN-1:0] pc_target;
  logic            flush;
  logic            instr_ready;
  logic            instr_valid;
  logic [ILEN-1:0] instr;
  logic [OP_W-1:0] op;
  logic [F3_W-1:0] f3;
  logic            f7;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            fetch_err;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, op, f3, f7, pc, pc_plus4, fetch_err,
    input  imem_rvalid, imem_rdata, pc_src, pc_target, flush, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, op, f3, f7, pc, pc_plus4, fetch_err,
    output imem_rvalid, imem_rdata, pc_src, pc_target, flush, instr_ready
  );

endinterface

// File: rtl/pc_next_mux.sv
// Next-PC selection: sequential pc+4 or word-aligned redirect target.
module pc_next_mux
  import rv32i_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_src_i,
  input  logic [XLEN-1:0] pc_target_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misalign_o
);

  logic redirect;

  // Redirect takes the target with its low two bits dropped; pc+4 wraps naturally.
  always_comb begin
    redirect   = flush_i | pc_src_i;
    pc_plus4_o = pc_i + XLEN'(4);
    next_pc_o  = redirect ? {pc_target_i[XLEN-1:2], 2'b00} : pc_plus4_o;
    misalign_o = redirect & (|pc_target_i[1:0]);
  end

endmodule

// File: rtl/instr_fetch.sv
// rv32i fetch stage: PC register, imem req/rvalid handshake, decode valid/ready.
module instr_fetch
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic            kill_q, kill_d;
  logic            fetch_err_q, fetch_err_d;

  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] pc_plus4;
  logic            misalign;

  pc_next_mux u_pc_next_mux (
    .pc_i        (pc_q),
    .pc_src_i    (bus.pc_src),
    .pc_target_i (bus.pc_target),
    .flush_i     (bus.flush),
    .pc_plus4_o  (pc_plus4),
    .next_pc_o   (next_pc),
    .misalign_o  (misalign)
  );

  // State and datapath registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IF_IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= NOP;
      kill_q      <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      kill_q      <= kill_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Next-state: flush beats accept; a killed response only clears the kill flag.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    kill_d      = kill_q;
    fetch_err_d = 1'b0;
    unique case (state_q)
      IF_IDLE: state_d = IF_REQ;
      IF_REQ: begin
        if (bus.flush) begin
          pc_d        = next_pc;
          fetch_err_d = misalign;
          // A same-cycle response settles the old request; otherwise drop the pending one.
          kill_d      = ~bus.imem_rvalid;
        end else if (bus.imem_rvalid) begin
          if (kill_q) begin
            kill_d = 1'b0;
          end else begin
            instr_d = bus.imem_rdata;
            state_d = IF_HOLD;
          end
        end
      end
      IF_HOLD: begin
        if (bus.flush || bus.instr_ready) begin
          pc_d        = next_pc;
          fetch_err_d = misalign;
          state_d     = IF_REQ;
        end
      end
      default: state_d = IF_IDLE;
    endcase
  end

  // Outputs are decodes/slices of registered state; pc_plus4 is combinational by design.
  always_comb begin
    bus.imem_req    = (state_q == IF_REQ);
    bus.imem_addr   = pc_q;
    bus.instr_valid = (state_q == IF_HOLD);
    bus.instr       = instr_q;
    bus.op          = instr_q[6:0];
    bus.f3          = instr_q[14:12];
    bus.f7          = instr_q[30];
    bus.pc          = pc_q;
    bus.pc_plus4    = pc_plus4;
    bus.fetch_err   = fetch_err_q;
  end

endmodule
